// File: rtl/regfile_pkg.sv
// Shared constants for the register file dump reader: default widths,
// number of registers dumped and the dump sequencer state encoding.
package regfile_pkg;

  // Register file geometry
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  // Dump sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying (register address, register data) words
// from the dump reader to whatever consumes the register dump.
interface regfile_dump_reader_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  // Producer side: drives the word and its valid flag, observes ready
  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  // Consumer side: observes the word, drives ready
  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/dump_skid_buf.sv
// Two-entry (address, data) FIFO. A pair of words is loaded at once and
// words leave one at a time through the valid/ready stream. The head is
// always slot 0, so the presented word never moves while it is stalled.
module dump_skid_buf
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              can_load,
  output logic              last_pop,
  regfile_dump_reader_if.master stream
);

  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] tail_addr;
  logic [DATA_W-1:0] tail_data;

  assign stream.out_valid = (count != 2'd0);
  assign stream.out_addr  = head_addr;
  assign stream.out_data  = head_data;

  assign pop = stream.out_valid && stream.out_ready;

  // A pair fits only if the buffer is empty or its single word leaves now
  assign can_load = (count == 2'd0) || ((count == 2'd1) && pop);
  assign last_pop = (count == 2'd1) && pop;

  // Occupancy after this edge: one out per handshake, two in per load
  always_comb begin
    count_next = count - {1'b0, pop} + (load ? 2'd2 : 2'd0);
  end

  // Load overwrites both slots; otherwise a pop shifts the tail to the head
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= 2'd0;
      head_addr <= '0;
      head_data <= '0;
      tail_addr <= '0;
      tail_data <= '0;
    end else begin
      count <= count_next;
      if (load) begin
        head_addr <= addr_a;
        head_data <= data_a;
        tail_addr <= addr_b;
        tail_data <= data_b;
      end else if (pop) begin
        head_addr <= tail_addr;
        head_data <= tail_data;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug dump port for the register file: on start, walks all registers in
// (even, odd) pairs over the two asynchronous read ports and streams each
// register out as an (address, data) word through a two-entry skid buffer.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] RsAddr,
  output logic [ADDR_W-1:0] RtAddr,
  input  logic [DATA_W-1:0] RsData,
  input  logic [DATA_W-1:0] RtData,
  regfile_dump_reader_if.master stream,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state;
  logic [ADDR_W-2:0] k;
  logic              can_load;
  logic              last_pop;
  logic              load;
  logic              last_pair;

  assign load      = (state == ST_READ) && can_load;
  assign last_pair = ({k, 1'b1} == LAST_ADDR);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Read addresses follow the pair index only while reading, else park at 0
  always_comb begin
    RsAddr = '0;
    RtAddr = '0;
    if (state == ST_READ) begin
      RsAddr = {k, 1'b0};
      RtAddr = {k, 1'b1};
    end
  end

  // Dump sequencer and pair counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      k     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_READ;
            k     <= '0;
          end
        end
        ST_READ: begin
          if (load) begin
            if (last_pair) begin
              state <= ST_DRAIN;
              k     <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dump_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .addr_a   (RsAddr),
    .data_a   (RsData),
    .addr_b   (RtAddr),
    .data_b   (RtData),
    .can_load (can_load),
    .last_pop (last_pop),
    .stream   (stream)
  );

endmodule
